// File: rtl/iomem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iomem_pkg
// Description : Shared types and constants for PicoSoC iomem initiators and
//               the peripheral responders that sit behind the iomem arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package iomem_pkg;

  localparam int unsigned IOMEM_AW = 32;
  localparam int unsigned IOMEM_DW = 32;
  localparam int unsigned IOMEM_SW = 4;

  // Address bits [31:24] select the peripheral behind the iomem window.
  localparam logic [7:0] GPIO_REGION = 8'h03;
  localparam logic [7:0] VGA_REGION  = 8'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } iomem_state_e;

  function automatic logic is_misaligned(input logic [IOMEM_AW-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iomem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : iomem_initiator
// Description : Single-outstanding iomem bus master with valid/ready command
//               and response ports, bus timeout and alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IOMEM_AW-1:0] cmd_addr,
  input  logic [IOMEM_DW-1:0] cmd_wdata,
  input  logic [IOMEM_SW-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IOMEM_DW-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [IOMEM_AW-1:0] mem_addr,
  output logic [IOMEM_DW-1:0] mem_wdata,
  output logic [IOMEM_SW-1:0] mem_wstrb,
  input  logic [IOMEM_DW-1:0] mem_rdata
);

  localparam int unsigned   CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  iomem_state_e        r_state,     w_state_n;
  logic [CNT_W-1:0]    r_cnt,       w_cnt_n;
  logic                r_cmd_ready, w_cmd_ready_n;
  logic                r_mem_valid, w_mem_valid_n;
  logic [IOMEM_AW-1:0] r_mem_addr,  w_mem_addr_n;
  logic [IOMEM_DW-1:0] r_mem_wdata, w_mem_wdata_n;
  logic [IOMEM_SW-1:0] r_mem_wstrb, w_mem_wstrb_n;
  logic                r_rsp_valid, w_rsp_valid_n;
  logic [IOMEM_DW-1:0] r_rsp_rdata, w_rsp_rdata_n;
  logic                r_rsp_err,   w_rsp_err_n;
  logic                w_accept;

  assign w_accept = cmd_valid && r_cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_cmd_ready <= w_cmd_ready_n;
      r_mem_valid <= w_mem_valid_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_wstrb <= w_mem_wstrb_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_rdata <= w_rsp_rdata_n;
      r_rsp_err   <= w_rsp_err_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_mem_valid_n = r_mem_valid;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_wstrb_n = r_mem_wstrb;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_rdata_n = r_rsp_rdata;
    w_rsp_err_n   = r_rsp_err;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_mem_addr_n  = cmd_addr;
          w_mem_wdata_n = cmd_wdata;
          w_mem_wstrb_n = cmd_wstrb;
          if (CHECK_ALIGN && is_misaligned(cmd_addr)) begin
            w_state_n     = RESP;
            w_rsp_valid_n = 1'b1;
            w_rsp_err_n   = 1'b1;
            w_rsp_rdata_n = '0;
          end else begin
            w_state_n     = BUS;
            w_mem_valid_n = 1'b1;
            w_cnt_n       = '0;
          end
        end
      end

      BUS: begin
        // mem_ready is checked first so a completion on the limit cycle wins.
        if (mem_ready) begin
          w_state_n     = RESP;
          w_mem_valid_n = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b0;
          w_rsp_rdata_n = (r_mem_wstrb == '0) ? mem_rdata : '0;
        end else if (r_cnt == CNT_LIMIT) begin
          w_state_n     = RESP;
          w_mem_valid_n = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b1;
          w_rsp_rdata_n = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_state_n     = IDLE;
          w_rsp_valid_n = 1'b0;
        end
      end

      default: begin
        w_state_n     = IDLE;
        w_mem_valid_n = 1'b0;
        w_rsp_valid_n = 1'b0;
      end
    endcase

    // Registered ready: high exactly in the cycles the FSM sits in IDLE.
    w_cmd_ready_n = (w_state_n == IDLE);
  end

  assign cmd_ready = r_cmd_ready;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
